// File: rtl/wt_buf_rd_pkg.sv
// Shared CNN-derived sizing for the weight-buffer read path.
// Weight word width, buffer depth, Tout and SRAM read latency all come from here.
package wt_buf_rd_pkg;

    localparam int TOUT     = 8;
    localparam int TIN      = 8;
    localparam int WT_DW    = 8;
    localparam int BUF_DEP  = 1024;

    // One weight word carries every Tout lane's Tin weights.
    localparam int WT_DATA_W            = TOUT * TIN * WT_DW;
    localparam int TOTAL_BUF_RD_LATENCY = 3;
    localparam int LOG2_BUF_DEP         = $clog2(BUF_DEP);
    localparam int LOG2_TOUT            = $clog2(TOUT);

    localparam int MIN_RD_LAT = 1;
    localparam int MAX_RD_LAT = 8;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/wt_buf_rd_if.sv
// Address, SRAM and CMAC channels of the weight-buffer read stage.
// slave is the read stage's view; master is the surrounding environment's view.
interface wt_buf_rd_if
    import wt_buf_rd_pkg::*;
#(
    parameter int DATA_W = WT_DATA_W,
    parameter int ADDR_W = LOG2_BUF_DEP,
    parameter int CNT_W  = LOG2_TOUT
);

    logic              addr_vld;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  addr_cnt;
    logic              addr_last;
    logic              addr_rdy;

    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;

    logic              wt_vld;
    logic [DATA_W-1:0] wt_data;
    logic [CNT_W-1:0]  wt_cnt;
    logic              wt_last;
    logic              wt_rdy;

    modport slave (
        input  addr_vld, addr, addr_cnt, addr_last, mem_rd_data, wt_rdy,
        output addr_rdy, mem_rd_en, mem_rd_addr, wt_vld, wt_data, wt_cnt, wt_last
    );

    modport master (
        output addr_vld, addr, addr_cnt, addr_last, mem_rd_data, wt_rdy,
        input  addr_rdy, mem_rd_en, mem_rd_addr, wt_vld, wt_data, wt_cnt, wt_last
    );

endinterface

// File: rtl/wt_buf_rd_fifo.sv
// Show-ahead synchronous FIFO: head_data is the oldest entry whenever empty is low.
// Storage is not reset; only the pointers and count are. clr empties it in one cycle.
module wt_rd_fifo
    import wt_buf_rd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = ptr_width(DEPTH),
    localparam int CNT_W = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem_reg [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             pop_ok;

    assign pop_ok = pop & (count_reg != '0);

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (clr) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_next = (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
            end
            case ({push, pop_ok})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    assign head_data = mem_reg[rd_ptr_reg];
    assign count     = count_reg;
    assign empty     = (count_reg == '0);
    assign full      = (count_reg == CNT_W'(DEPTH));

endmodule

// File: rtl/wt_buf_rd.sv
// Weight-buffer read stage: issues SRAM reads on address accept, realigns returned
// words with their {cnt,last} tags and hands them to CMAC through a credit-guarded FIFO.
module wt_buf_rd
    import wt_buf_rd_pkg::*;
#(
    parameter int DATA_W   = WT_DATA_W,
    parameter int ADDR_W   = LOG2_BUF_DEP,
    parameter int CNT_W    = LOG2_TOUT,
    parameter int RD_LAT   = TOTAL_BUF_RD_LATENCY,
    parameter int FIFO_DEP = RD_LAT + 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    wt_buf_rd_if.slave bus,
    output logic       busy
);

    localparam int ENT_W  = DATA_W + CNT_W + 1;
    localparam int OCC_W  = count_width(FIFO_DEP);
    localparam int CRED_W = $clog2(FIFO_DEP + RD_LAT + 1);

    logic              rdy_en_reg;
    logic              credit_ok;
    logic              addr_rdy;
    logic              accept;

    logic [RD_LAT-1:0] tag_vld;
    logic [CNT_W-1:0]  tag_cnt [RD_LAT];
    logic [RD_LAT-1:0] tag_last;
    logic [CRED_W-1:0] inflight;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_empty;
    logic              fifo_full;
    logic [OCC_W-1:0]  fifo_count;
    logic [ENT_W-1:0]  fifo_head;
    logic [ENT_W-1:0]  fifo_in;

    // Holds addr_rdy low through reset; it opens on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en_reg <= 1'b0;
        end else begin
            rdy_en_reg <= 1'b1;
        end
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CRED_W'(tag_vld[i]);
        end
    end

    // Every outstanding read owns a FIFO slot, so a push can never meet a full FIFO.
    assign credit_ok = (CRED_W'(fifo_count) + inflight) < CRED_W'(FIFO_DEP);
    assign addr_rdy  = rdy_en_reg & credit_ok & ~start;
    assign accept    = bus.addr_vld & addr_rdy;

    assign bus.addr_rdy    = addr_rdy;
    assign bus.mem_rd_en   = accept;
    assign bus.mem_rd_addr = accept ? bus.addr : '0;

    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_tag
            logic             in_vld;
            logic [CNT_W-1:0] in_cnt;
            logic             in_last;
            logic             vld_reg;
            logic [CNT_W-1:0] cnt_reg;
            logic             last_reg;

            if (gi == 0) begin : g_src
                assign in_vld  = accept;
                assign in_cnt  = bus.addr_cnt;
                assign in_last = bus.addr_last;
            end else begin : g_src
                assign in_vld  = tag_vld[gi-1];
                assign in_cnt  = tag_cnt[gi-1];
                assign in_last = tag_last[gi-1];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_reg  <= 1'b0;
                    cnt_reg  <= '0;
                    last_reg <= 1'b0;
                end else begin
                    vld_reg  <= in_vld & ~start;
                    cnt_reg  <= in_cnt;
                    last_reg <= in_last;
                end
            end

            assign tag_vld[gi]  = vld_reg;
            assign tag_cnt[gi]  = cnt_reg;
            assign tag_last[gi] = last_reg;
        end
    endgenerate

    // The last tag stage lines up with the SRAM data of the same read.
    assign fifo_in   = {bus.mem_rd_data, tag_cnt[RD_LAT-1], tag_last[RD_LAT-1]};
    assign fifo_pop  = ~fifo_empty & bus.wt_rdy;
    assign fifo_push = tag_vld[RD_LAT-1] & ~start & (~fifo_full | fifo_pop);

    wt_rd_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEP)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (start),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Outputs read zero while empty so unreset FIFO storage never shows on the bus.
    assign bus.wt_vld  = ~fifo_empty;
    assign bus.wt_data = fifo_empty ? '0 : fifo_head[ENT_W-1 -: DATA_W];
    assign bus.wt_cnt  = fifo_empty ? '0 : fifo_head[CNT_W:1];
    assign bus.wt_last = ~fifo_empty & fifo_head[0];

    assign busy = (inflight != '0) | ~fifo_empty;

endmodule

// File: tb/tb_wt_buf_rd.sv
// Bench for wt_buf_rd at RD_LAT 1, 3 and 8 against a queue-based model of the
// accepted-but-not-delivered words.
module tb_wt_buf_rd;

    localparam int DW   = 512;
    localparam int AW   = 10;
    localparam int CW   = 3;
    localparam int NCFG = 3;

    typedef struct {
        logic [DW-1:0] data;
        logic [CW-1:0] cnt;
        logic          last;
        int            avail;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic          in_vld   [NCFG];
    logic [AW-1:0] in_addr  [NCFG];
    logic [CW-1:0] in_cnt   [NCFG];
    logic          in_last  [NCFG];
    logic          in_rdy   [NCFG];
    logic          in_start [NCFG];

    logic          o_addr_rdy [NCFG];
    logic          o_mem_en   [NCFG];
    logic [AW-1:0] o_mem_addr [NCFG];
    logic          o_wt_vld   [NCFG];
    logic [DW-1:0] o_wt_data  [NCFG];
    logic [CW-1:0] o_wt_cnt   [NCFG];
    logic          o_wt_last  [NCFG];
    logic          o_busy     [NCFG];

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) begin
            w[i*32 +: 32] = (32'(a) * 32'h9E37_79B1) ^ (32'(i) * 32'h0101_0101) ^ 32'(a);
        end
        return w;
    endfunction

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 8);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NCFG; gi++) begin : g_cfg
            localparam int L = (gi == 0) ? 1 : ((gi == 1) ? 3 : 8);
            wt_buf_rd_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) bus ();
            logic [DW-1:0] pipe [L];

            assign bus.addr_vld  = in_vld[gi];
            assign bus.addr      = in_addr[gi];
            assign bus.addr_cnt  = in_cnt[gi];
            assign bus.addr_last = in_last[gi];
            assign bus.wt_rdy    = in_rdy[gi];
            assign bus.mem_rd_data = pipe[L-1];

            assign o_addr_rdy[gi] = bus.addr_rdy;
            assign o_mem_en[gi]   = bus.mem_rd_en;
            assign o_mem_addr[gi] = bus.mem_rd_addr;
            assign o_wt_vld[gi]   = bus.wt_vld;
            assign o_wt_data[gi]  = bus.wt_data;
            assign o_wt_cnt[gi]   = bus.wt_cnt;
            assign o_wt_last[gi]  = bus.wt_last;

            // Fixed-latency SRAM; idle cycles return garbage so misaligned capture shows up.
            always @(posedge clk) begin
                pipe[0] <= bus.mem_rd_en ? mem_word(bus.mem_rd_addr) : {(DW / 32){$urandom}};
                for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
            end

            wt_buf_rd #(
                .DATA_W (DW), .ADDR_W (AW), .CNT_W (CW), .RD_LAT (L), .FIFO_DEP (L + 2)
            ) dut (
                .clk   (clk),
                .rst_n (rst_n),
                .start (in_start[gi]),
                .bus   (bus),
                .busy  (o_busy[gi])
            );
        end
    endgenerate

    exp_t          q[$];
    int            n_assert = 0;
    int            n_fail   = 0;
    int            outst_obs;
    logic          seen_acc, seen_pop, seen_vld, seen_last;
    logic [DW-1:0] seen_data;
    logic [CW-1:0] seen_cnt;
    int            seen_cyc;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of config k: check outputs at negedge, advance the model, return at posedge+1.
    task automatic tick(input int k);
        int   lat, dep;
        logic exp_rdy, acc, exp_vld, pop;
        lat = lat_of(k);
        dep = lat + 2;
        @(negedge clk);
        exp_rdy = !in_start[k] && (q.size() < dep);
        chk("addr_rdy", o_addr_rdy[k], exp_rdy);
        acc = in_vld[k] && exp_rdy;
        chk("mem_rd_en", o_mem_en[k], acc);
        chk("mem_rd_addr", o_mem_addr[k], acc ? in_addr[k] : '0);
        exp_vld = (q.size() > 0) && (q[0].avail <= cyc);
        chk("wt_vld", o_wt_vld[k], exp_vld);
        if (exp_vld) begin
            chk("wt_data", o_wt_data[k], q[0].data);
            chk("wt_cnt", o_wt_cnt[k], q[0].cnt);
            chk("wt_last", o_wt_last[k], q[0].last);
        end
        chk("busy", o_busy[k], q.size() > 0);

        seen_acc  = o_mem_en[k];
        seen_pop  = o_wt_vld[k] && in_rdy[k];
        seen_vld  = o_wt_vld[k];
        seen_data = o_wt_data[k];
        seen_cnt  = o_wt_cnt[k];
        seen_last = o_wt_last[k];
        seen_cyc  = cyc;

        if (in_start[k]) outst_obs = 0;
        else outst_obs = outst_obs + int'(seen_acc) - int'(seen_pop);
        chk("no_overflow", outst_obs <= dep, 1'b1);

        pop = exp_vld && in_rdy[k];
        if (pop) void'(q.pop_front());
        if (in_start[k]) q.delete();
        else if (acc) q.push_back('{mem_word(in_addr[k]), in_cnt[k], in_last[k], cyc + lat + 1});
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int k);
        in_vld[k] = 1'b0;
        in_rdy[k] = 1'b1;
        for (int i = 0; i < 40 && q.size() > 0; i++) tick(k);
        tick(k);
    endtask

    task automatic run_stream(input int k);
        int n_pop = 0;
        in_rdy[k] = 1'b1;
        for (int i = 0; i < 64; i++) begin
            in_vld[k]  = 1'b1;
            in_addr[k] = AW'(i * 13 + k);
            in_cnt[k]  = CW'(i);
            in_last[k] = (i % 8 == 7);
            tick(k);
            n_pop += int'(seen_pop);
        end
        in_vld[k] = 1'b0;
        for (int i = 0; i < lat_of(k) + 4; i++) begin
            tick(k);
            n_pop += int'(seen_pop);
        end
        chk("stream_pops", n_pop, 64);
    endtask

    task automatic run_backpressure(input int k);
        int dep, n_acc, n_pop;
        dep = lat_of(k) + 2;
        n_acc = 0;
        n_pop = 0;
        in_rdy[k] = 1'b0;
        for (int i = 0; i < dep + 4; i++) begin
            in_vld[k] = 1'b1;
            if (i == 0 || seen_acc) begin
                in_addr[k] = AW'($urandom_range(0, 1023));
                in_cnt[k]  = CW'($urandom_range(0, 7));
                in_last[k] = 1'($urandom_range(0, 1));
            end
            tick(k);
            n_acc += int'(seen_acc);
        end
        chk("bp_accepts", n_acc, dep);
        in_vld[k] = 1'b0;
        in_rdy[k] = 1'b1;
        for (int i = 0; i < dep + lat_of(k) + 4; i++) begin
            tick(k);
            n_pop += int'(seen_pop);
        end
        chk("bp_pops", n_pop, dep);
    endtask

    task automatic run_random(input int k, input int n_words);
        int n_acc = 0;
        int guard = 0;
        in_vld[k] = 1'b0;
        while (n_acc < n_words && guard < n_words * 8) begin
            if (!in_vld[k] || seen_acc) begin
                in_addr[k] = AW'($urandom_range(0, 1023));
                in_cnt[k]  = CW'($urandom_range(0, 7));
                in_last[k] = 1'($urandom_range(0, 1));
            end
            in_vld[k] = ($urandom_range(0, 3) != 0);
            in_rdy[k] = 1'($urandom_range(0, 1));
            tick(k);
            n_acc += int'(seen_acc);
            guard++;
        end
        chk("rand_accepts", n_acc, n_words);
        drain(k);
    endtask

    task automatic run_single();
        int c0;
        in_rdy[1]  = 1'b1;
        in_vld[1]  = 1'b1;
        in_addr[1] = AW'(12'h012);
        in_cnt[1]  = 3'd5;
        in_last[1] = 1'b1;
        c0 = cyc;
        tick(1);
        in_vld[1] = 1'b0;
        for (int i = 0; i < 3; i++) tick(1);
        chk("single_cycle", seen_cyc, c0 + 3);
        tick(1);
        chk("single_vld_T+4", seen_vld, 1'b1);
        chk("single_data", seen_data, mem_word(AW'(12'h012)));
        chk("single_cnt", seen_cnt, 3'd5);
        chk("single_last", seen_last, 1'b1);
        drain(1);
    endtask

    task automatic run_flush();
        int n_pop = 0;
        in_rdy[1] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_vld[1]  = 1'b1;
            in_addr[1] = AW'(12'h100 + i);
            in_cnt[1]  = CW'(i);
            in_last[1] = (i == 4);
            tick(1);
        end
        in_start[1] = 1'b1;
        in_addr[1]  = AW'(12'h3FF);
        tick(1);
        chk("flush_start_acc", seen_acc, 1'b0);
        in_start[1] = 1'b0;
        in_vld[1]   = 1'b0;
        in_rdy[1]   = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            n_pop += int'(seen_pop);
        end
        chk("flush_no_stale", n_pop, 0);
        in_vld[1]  = 1'b1;
        in_addr[1] = AW'(12'h2A5);
        in_cnt[1]  = 3'd2;
        in_last[1] = 1'b0;
        tick(1);
        in_vld[1] = 1'b0;
        n_pop = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (seen_pop) begin
                n_pop++;
                chk("flush_new_data", seen_data, mem_word(AW'(12'h2A5)));
            end
        end
        chk("flush_new_pops", n_pop, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        seen_acc = 1'b0;
        outst_obs = 0;
        for (int k = 0; k < NCFG; k++) begin
            in_vld[k]   = 1'b1;
            in_addr[k]  = AW'(k * 5 + 1);
            in_cnt[k]   = CW'(k + 1);
            in_last[k]  = 1'b1;
            in_rdy[k]   = 1'b0;
            in_start[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NCFG; k++) begin
            chk("rst_addr_rdy", o_addr_rdy[k], 1'b0);
            chk("rst_mem_rd_en", o_mem_en[k], 1'b0);
            chk("rst_mem_rd_addr", o_mem_addr[k], '0);
            chk("rst_wt_vld", o_wt_vld[k], 1'b0);
            chk("rst_wt_data", o_wt_data[k], '0);
            chk("rst_wt_cnt", o_wt_cnt[k], '0);
            chk("rst_wt_last", o_wt_last[k], 1'b0);
            chk("rst_busy", o_busy[k], 1'b0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < NCFG; k++) in_vld[k] = 1'b0;
        @(posedge clk);
        #1;

        for (int k = 0; k < NCFG; k++) begin
            q.delete();
            outst_obs = 0;
            run_stream(k);
            run_backpressure(k);
            if (k == 1) begin
                run_single();
                run_flush();
            end
            run_random(k, (k == 1) ? 1000 : 300);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/wt_buf_rd.md
# wt_buf_rd

Weight-buffer read stage between the weight address FSM and the CMAC weight-register array. It accepts weight addresses with their Tout slot index and last-of-group flag over a valid/ready handshake, then issues reads to the fixed-latency weight SRAM. Returned words are re-aligned with their tags and delivered to CMAC over a second valid/ready handshake. A credit-based output FIFO lets CMAC back-pressure without losing in-flight reads.

## Interface
- DATA_W, default 512: weight word width (Tout lanes × Tin × WT_DW, set by the CNN defines).
- ADDR_W, default `log2BUF_DEP`: weight buffer address width.
- CNT_W, default `log2Tout`: width of the Tout slot index.
- RD_LAT, default `TOTAL_BUF_RD_LATENCY`: SRAM read latency in cycles; legal range 1..8.
- FIFO_DEP, default RD_LAT+2: output FIFO depth; must be at least RD_LAT+2.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  layer start; synchronous flush of all internal state.
- addr_vld  in  1  address valid from the weight FSM.
- addr  in  ADDR_W  weight buffer address.
- addr_cnt  in  CNT_W  Tout slot the word belongs to.
- addr_last  in  1  last word of a Ky·Kx·CHin/Tin group.
- addr_rdy  out  1  address accepted when high together with addr_vld.
- mem_rd_en  out  1  SRAM read enable.
- mem_rd_addr  out  ADDR_W  SRAM read address.
- mem_rd_data  in  DATA_W  SRAM data, valid RD_LAT cycles after mem_rd_en.
- wt_vld  out  1  weight word valid to CMAC.
- wt_data  out  DATA_W  weight word.
- wt_cnt  out  CNT_W  slot index aligned with wt_data.
- wt_last  out  1  last flag aligned with wt_data.
- wt_rdy  in  1  CMAC ready.
- busy  out  1  high while any read is in flight or the FIFO is non-empty.

## Operation
- Accept = addr_vld & addr_rdy.
- On accept, drive mem_rd_en = 1 and mem_rd_addr = addr in the same cycle. Both are combinational from the handshake, with no added cycle.
- Tag pipeline: RD_LAT stages of {vld, addr_cnt, addr_last}.
  - Stage 0 loads on accept.
  - At the edge closing cycle T+RD_LAT, if the last stage's vld is set, push {mem_rd_data, cnt, last} into the FIFO.
- The FIFO is show-ahead: wt_vld = !empty, and wt_data/wt_cnt/wt_last are the head entry.
  - Pop = wt_vld & wt_rdy.
  - Simultaneous push and pop leaves occupancy unchanged.
- Credit counting:
  - inflight = number of set tag vld bits.
  - addr_rdy = (occupancy + inflight < FIFO_DEP) & !start.
  - occupancy and inflight are the registered values. A pop in the current cycle frees credit only from the next cycle.
  - This rule guarantees a push never meets a full FIFO. Overflow is unreachable; the bench checks for it.
- start (synchronous, highest priority):
  - clears all tag vld bits, empties the FIFO and holds addr_rdy low for that cycle.
  - SRAM data for reads issued before start is discarded.
  - an addr_vld presented in the start cycle is not accepted.
- Reset values: addr_rdy 0, mem_rd_en 0, mem_rd_addr 0, wt_vld 0, wt_data 0, wt_cnt 0, wt_last 0, busy 0. The tag pipeline and FIFO pointers are 0.
  - addr_rdy rises in the first cycle after rst_n deasserts.
  - FIFO storage is not reset; only its pointers are.
- Order: words leave in exactly the order addresses were accepted.
- Nothing is dropped or duplicated except by start.

## Timing
- Address accepted in cycle T → wt_vld high in cycle T+RD_LAT+1 at the earliest. Minimum latency is RD_LAT+1.
- With wt_rdy held high, sustained throughput is one word per cycle. Steady state: occupancy ≤ 1, inflight = RD_LAT.
- When wt_rdy drops, addr_rdy falls once occupancy+inflight reaches FIFO_DEP.
  - At most FIFO_DEP words are outstanding.
  - addr_rdy recovers the cycle after the first pop.
- wt_* outputs hold stable while wt_vld & !wt_rdy.
- busy = (inflight != 0) | !empty, derived from registered state.

## Structure
- Shared package/defines: DATA_W derivation from Tout/Tin/WT_DW, `TOTAL_BUF_RD_LATENCY`, `log2BUF_DEP`, `log2Tout`.
- One sub-module: wt_rd_fifo, a show-ahead synchronous FIFO.
  - Parameters: width, depth.
  - Outputs: occupancy count, empty/full.
- The tag pipeline and credit logic live in the top.

## Test plan
- Reset: hold rst_n low with addr_vld=1 → all outputs 0. After release, addr_rdy=1 next cycle.
- Single read, RD_LAT=3: addr=0x12, cnt=5, last=1 accepted in cycle 10 → mem_rd_en/mem_rd_addr=0x12 in cycle 10; wt_vld, data=mem[0x12], cnt=5, last=1 in cycle 14.
- Streaming: 64 consecutive addresses, wt_rdy=1 → addr_rdy never drops; 64 words leave in order on consecutive cycles.
- Back-pressure: wt_rdy=0 from the start, RD_LAT=3, FIFO_DEP=5 → exactly 5 accepts, then addr_rdy=0. Release wt_rdy → 5 words in order, no loss; random wt_rdy over 1000 words gives a scoreboard match.
- Flush: pulse start while 3 reads are in flight and 2 words are queued → wt_vld=0 next cycle; no stale word appears; a new address returns only its own data.
- Corner parameters: rerun streaming and back-pressure with RD_LAT=1 and RD_LAT=8 → same ordering. Assert the FIFO never overflows.
